// File: rtl/axi4_regbank_pkg.sv
// Shared constants and helpers for the AXI4-Lite register bank.
package axi4_regbank_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((32'd1 << res) < value) res = res + 1;
    return res;
  endfunction

endpackage

// File: rtl/axi4_regbank_if.sv
// AXI4-Lite bus bundle between an interconnect master and the register bank.
interface axi4_regbank_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32
);
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_W-1:0]     awaddr;
  logic [2:0]            awprot;
  logic                  wvalid;
  logic                  wready;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_W-1:0]     araddr;
  logic [2:0]            arprot;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_W-1:0]     rdata;
  logic [1:0]            rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    output arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    input  arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi4l_slave_if.sv
// AXI4-Lite handshake front end: holds AW/W/AR until the transaction is answered and
// turns them into single-cycle write/read requests for the register core.
module axi4l_slave_if import axi4_regbank_pkg::*; #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 2,
  parameter int unsigned BYTE_W = 2
) (
  input  logic                aclk,
  input  logic                areset,
  axi4_regbank_if.slave       bus,
  output logic                wr_req_o,
  output logic [IDX_W-1:0]    wr_idx_o,
  output logic [DATA_W-1:0]   wr_data_o,
  output logic [DATA_W/8-1:0] wr_strb_o,
  input  logic                wr_ack_i,
  input  logic                wr_err_i,
  output logic                rd_req_o,
  output logic [IDX_W-1:0]    rd_idx_o,
  input  logic                rd_ack_i,
  input  logic                rd_err_i,
  input  logic [DATA_W-1:0]   rd_data_i
);
  localparam int unsigned ADDR_W = IDX_W + BYTE_W;

  logic                rst_done_q, rst_done_d;
  logic                aw_held_q, aw_held_d, w_held_q, w_held_d, wr_issued_q, wr_issued_d;
  logic [IDX_W-1:0]    aw_idx_q, aw_idx_d;
  logic [DATA_W-1:0]   w_data_q, w_data_d;
  logic [DATA_W/8-1:0] w_strb_q, w_strb_d;
  logic                bvalid_q, bvalid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic                ar_held_q, ar_held_d, rd_issued_q, rd_issued_d;
  logic [IDX_W-1:0]    ar_idx_q, ar_idx_d;
  logic                rvalid_q, rvalid_d;
  logic [1:0]          rresp_q, rresp_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic                unused_bits;

  assign unused_bits = ^{bus.awprot, bus.arprot, bus.awaddr[BYTE_W-1:0], bus.araddr[BYTE_W-1:0]};

  // Ready stays low while reset is applied and until the first edge after release.
  assign bus.awready = rst_done_q & ~aw_held_q;
  assign bus.wready  = rst_done_q & ~w_held_q;
  assign bus.arready = rst_done_q & ~ar_held_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rresp   = rresp_q;
  assign bus.rdata   = rdata_q;

  assign wr_req_o  = aw_held_q & w_held_q & ~wr_issued_q;
  assign wr_idx_o  = aw_idx_q;
  assign wr_data_o = w_data_q;
  assign wr_strb_o = w_strb_q;
  assign rd_req_o  = ar_held_q & ~rd_issued_q;
  assign rd_idx_o  = ar_idx_q;

  always_comb begin
    rst_done_d  = 1'b1;
    aw_held_d   = aw_held_q;
    aw_idx_d    = aw_idx_q;
    w_held_d    = w_held_q;
    w_data_d    = w_data_q;
    w_strb_d    = w_strb_q;
    wr_issued_d = wr_issued_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    ar_held_d   = ar_held_q;
    ar_idx_d    = ar_idx_q;
    rd_issued_d = rd_issued_q;
    rvalid_d    = rvalid_q;
    rresp_d     = rresp_q;
    rdata_d     = rdata_q;

    aw_hs = bus.awvalid & bus.awready;
    w_hs  = bus.wvalid & bus.wready;
    b_hs  = bvalid_q & bus.bready;
    ar_hs = bus.arvalid & bus.arready;
    r_hs  = rvalid_q & bus.rready;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_idx_d  = bus.awaddr[ADDR_W-1:BYTE_W];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      w_data_d = bus.wdata;
      w_strb_d = bus.wstrb;
    end
    if (wr_req_o) wr_issued_d = 1'b1;
    if (wr_ack_i) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_err_i ? RESP_SLVERR : RESP_OKAY;
    end
    if (b_hs) begin
      bvalid_d    = 1'b0;
      aw_held_d   = 1'b0;
      w_held_d    = 1'b0;
      wr_issued_d = 1'b0;
    end

    if (ar_hs) begin
      ar_held_d = 1'b1;
      ar_idx_d  = bus.araddr[ADDR_W-1:BYTE_W];
    end
    if (rd_req_o) rd_issued_d = 1'b1;
    if (rd_ack_i) begin
      rvalid_d = 1'b1;
      rresp_d  = rd_err_i ? RESP_SLVERR : RESP_OKAY;
      rdata_d  = rd_data_i;
    end
    if (r_hs) begin
      rvalid_d    = 1'b0;
      ar_held_d   = 1'b0;
      rd_issued_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rst_done_q  <= 1'b0;
      aw_held_q   <= 1'b0;
      aw_idx_q    <= '0;
      w_held_q    <= 1'b0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      wr_issued_q <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
      ar_held_q   <= 1'b0;
      ar_idx_q    <= '0;
      rd_issued_q <= 1'b0;
      rvalid_q    <= 1'b0;
      rresp_q     <= RESP_OKAY;
      rdata_q     <= '0;
    end else begin
      rst_done_q  <= rst_done_d;
      aw_held_q   <= aw_held_d;
      aw_idx_q    <= aw_idx_d;
      w_held_q    <= w_held_d;
      w_data_q    <= w_data_d;
      w_strb_q    <= w_strb_d;
      wr_issued_q <= wr_issued_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      ar_held_q   <= ar_held_d;
      ar_idx_q    <= ar_idx_d;
      rd_issued_q <= rd_issued_d;
      rvalid_q    <= rvalid_d;
      rresp_q     <= rresp_d;
      rdata_q     <= rdata_d;
    end
  end

endmodule

// File: rtl/axi4_regbank.sv
// Parametrised AXI4-Lite control register bank with byte strobes, SLVERR on unmapped
// addresses and per-register write pulses.
module axi4_regbank import axi4_regbank_pkg::*; #(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       NREGS       = 4,
  parameter logic [DATA_W-1:0] RESET_VALUE = '0
) (
  input  logic                    aclk,
  input  logic                    areset,
  axi4_regbank_if.slave           bus,
  output logic [NREGS*DATA_W-1:0] regs_o,
  output logic [NREGS-1:0]        wr_pulse_o
);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned BYTE_W = clog2(STRB_W);
  localparam int unsigned IDX_W  = (NREGS > 1) ? clog2(NREGS) : 1;

  logic                    wr_req, wr_ack_q, wr_ack_d, wr_err_q, wr_err_d, wr_hit;
  logic [IDX_W-1:0]        wr_idx;
  logic [DATA_W-1:0]       wr_data;
  logic [STRB_W-1:0]       wr_strb;
  logic                    rd_req, rd_ack_q, rd_ack_d, rd_err_q, rd_err_d;
  logic [IDX_W-1:0]        rd_idx;
  logic [DATA_W-1:0]       rd_data_q, rd_data_d;

  logic                    stg_valid_q, stg_valid_d, stg_err_q, stg_err_d;
  logic [IDX_W-1:0]        stg_idx_q, stg_idx_d;
  logic [DATA_W-1:0]       stg_data_q, stg_data_d;
  logic [STRB_W-1:0]       stg_strb_q, stg_strb_d;

  logic [NREGS*DATA_W-1:0] regs_q, regs_d;
  logic [NREGS-1:0]        pulse_q, pulse_d;

  assign regs_o     = regs_q;
  assign wr_pulse_o = pulse_q;

  axi4l_slave_if #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W),
    .BYTE_W (BYTE_W)
  ) u_slave (
    .aclk      (aclk),
    .areset    (areset),
    .bus       (bus),
    .wr_req_o  (wr_req),
    .wr_idx_o  (wr_idx),
    .wr_data_o (wr_data),
    .wr_strb_o (wr_strb),
    .wr_ack_i  (wr_ack_q),
    .wr_err_i  (wr_err_q),
    .rd_req_o  (rd_req),
    .rd_idx_o  (rd_idx),
    .rd_ack_i  (rd_ack_q),
    .rd_err_i  (rd_err_q),
    .rd_data_i (rd_data_q)
  );

  always_comb begin
    wr_hit = 1'b0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (wr_idx == IDX_W'(i)) wr_hit = 1'b1;
    end

    // Stage the write one cycle so commit lands two edges after the AW/W pair completes.
    stg_valid_d = wr_req;
    stg_idx_d   = stg_idx_q;
    stg_data_d  = stg_data_q;
    stg_strb_d  = stg_strb_q;
    stg_err_d   = stg_err_q;
    if (wr_req) begin
      stg_idx_d  = wr_idx;
      stg_data_d = wr_data;
      stg_strb_d = wr_strb;
      stg_err_d  = ~wr_hit;
    end

    regs_d   = regs_q;
    pulse_d  = '0;
    wr_ack_d = stg_valid_q;
    wr_err_d = stg_err_q;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (stg_valid_q && !stg_err_q && stg_idx_q == IDX_W'(i)) begin
        pulse_d[i] = 1'b1;
        for (int unsigned k = 0; k < STRB_W; k++) begin
          if (stg_strb_q[k]) regs_d[i*DATA_W + k*8 +: 8] = stg_data_q[k*8 +: 8];
        end
      end
    end

    // Sampling before the commit edge means a same-edge write is not yet visible.
    rd_ack_d  = rd_req;
    rd_err_d  = rd_err_q;
    rd_data_d = rd_data_q;
    if (rd_req) begin
      rd_err_d  = 1'b1;
      rd_data_d = '0;
      for (int unsigned i = 0; i < NREGS; i++) begin
        if (rd_idx == IDX_W'(i)) begin
          rd_err_d  = 1'b0;
          rd_data_d = regs_q[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      stg_valid_q <= 1'b0;
      stg_idx_q   <= '0;
      stg_data_q  <= '0;
      stg_strb_q  <= '0;
      stg_err_q   <= 1'b0;
      regs_q      <= {NREGS{RESET_VALUE}};
      pulse_q     <= '0;
      wr_ack_q    <= 1'b0;
      wr_err_q    <= 1'b0;
      rd_ack_q    <= 1'b0;
      rd_err_q    <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      stg_valid_q <= stg_valid_d;
      stg_idx_q   <= stg_idx_d;
      stg_data_q  <= stg_data_d;
      stg_strb_q  <= stg_strb_d;
      stg_err_q   <= stg_err_d;
      regs_q      <= regs_d;
      pulse_q     <= pulse_d;
      wr_ack_q    <= wr_ack_d;
      wr_err_q    <= wr_err_d;
      rd_ack_q    <= rd_ack_d;
      rd_err_q    <= rd_err_d;
      rd_data_q   <= rd_data_d;
    end
  end

endmodule

// File: tb/tb_axi4_regbank.sv
// Directed bench for axi4_regbank: 3 x 32-bit registers, reset value DEADBEEF.
module tb_axi4_regbank;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NREGS  = 3;
  localparam int unsigned ADDR_W = 4;
  localparam logic [31:0] RV     = 32'hDEAD_BEEF;

  logic                    aclk = 1'b0;
  logic                    areset = 1'b1;
  logic [NREGS*DATA_W-1:0] regs;
  logic [NREGS-1:0]        pulse;
  int                      checks = 0;
  int                      errors = 0;

  axi4_regbank_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  axi4_regbank #(
    .DATA_W      (DATA_W),
    .NREGS       (NREGS),
    .RESET_VALUE (RV)
  ) dut (
    .aclk       (aclk),
    .areset     (areset),
    .bus        (bus),
    .regs_o     (regs),
    .wr_pulse_o (pulse)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [1:0] resp,
                          output logic [NREGS-1:0] pulses);
    bit aw_done = 0, w_done = 0, got = 0, aw_go, w_go;
    pulses = '0;
    resp = 2'bxx;
    bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    for (int n = 0; n < 20 && !(aw_done && w_done); n++) begin
      aw_go = bus.awvalid & bus.awready;
      w_go  = bus.wvalid & bus.wready;
      tick();
      if (aw_go) begin bus.awvalid = 1'b0; aw_done = 1; end
      if (w_go)  begin bus.wvalid = 1'b0;  w_done = 1;  end
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b1;
    for (int n = 0; n < 20 && !got; n++) begin
      pulses |= pulse;
      if (bus.bvalid) begin resp = bus.bresp; got = 1; end
      tick();
    end
    bus.bready = 1'b0;
    if (!got) check("write_timeout", 0, 1);
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] addr, output logic [31:0] data,
                         output logic [1:0] resp);
    bit ar_done = 0, got = 0, ar_go;
    data = 'x; resp = 2'bxx;
    bus.araddr = addr; bus.arvalid = 1'b1;
    for (int n = 0; n < 20 && !ar_done; n++) begin
      ar_go = bus.arready;
      tick();
      if (ar_go) ar_done = 1;
    end
    bus.arvalid = 1'b0;
    bus.rready = 1'b1;
    for (int n = 0; n < 20 && !got; n++) begin
      if (bus.rvalid) begin data = bus.rdata; resp = bus.rresp; got = 1; end
      tick();
    end
    bus.rready = 1'b0;
    if (!got) check("read_timeout", 0, 1);
  endtask

  initial begin
    logic [1:0]       resp, bresp_s, rresp_s;
    logic [31:0]      rdata_s;
    logic [NREGS-1:0] pulses;
    bit               bgot, rgot;

    bus.awvalid = 0; bus.awaddr = '0; bus.awprot = '0;
    bus.wvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.bready = 0;
    bus.arvalid = 0; bus.araddr = '0; bus.arprot = '0; bus.rready = 0;

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    check("awready_in_reset", bus.awready, 0);
    areset = 1'b0;
    tick();
    check("rst_awready", bus.awready, 1);
    check("rst_wready", bus.wready, 1);
    check("rst_arready", bus.arready, 1);
    check("rst_bvalid", bus.bvalid, 0);
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_pulse", pulse, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_resp", {bus.bresp, bus.rresp}, 0);
    check("rst_regs", regs, {RV, RV, RV});

    // Clear reg1, then AW leading W by three cycles with sparse strobes
    do_write(4'h4, 32'h0, 4'hF, resp, pulses);
    check("clr_resp", resp, 2'b00);
    check("clr_reg1", regs[63:32], 32'h0);
    bus.awaddr = 4'h4; bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    check("aw_held_ready", bus.awready, 0);
    tick(); tick();
    bus.wdata = 32'h1234_5678; bus.wstrb = 4'b0101; bus.wvalid = 1'b1;
    tick();
    bus.wvalid = 1'b0;
    check("w_held_ready", bus.wready, 0);
    check("e0_reg1", regs[63:32], 32'h0);
    tick();
    check("e1_reg1", regs[63:32], 32'h0);
    check("e1_pulse", pulse, 3'b000);
    tick();
    check("e2_reg1", regs[63:32], 32'h0034_0078);
    check("e2_pulse", pulse, 3'b010);
    check("e2_bvalid", bus.bvalid, 0);
    tick();
    check("e3_pulse", pulse, 3'b000);
    check("e3_bvalid", bus.bvalid, 1);
    check("e3_bresp", bus.bresp, 2'b00);
    check("e3_awready", bus.awready, 0);
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    check("e4_bvalid", bus.bvalid, 0);
    check("e4_awready", bus.awready, 1);

    // Zero strobe still pulses but changes nothing
    do_write(4'h0, 32'hFFFF_FFFF, 4'h0, resp, pulses);
    check("zstrb_resp", resp, 2'b00);
    check("zstrb_pulse", pulses, 3'b001);
    check("zstrb_reg0", regs[31:0], RV);

    // Unmapped index 3
    do_write(4'hC, 32'hFFFF_FFFF, 4'hF, resp, pulses);
    check("unmap_bresp", resp, 2'b10);
    check("unmap_pulse", pulses, 3'b000);
    check("unmap_regs", regs, {RV, 32'h0034_0078, RV});
    do_read(4'hC, rdata_s, resp);
    check("unmap_rresp", resp, 2'b10);
    check("unmap_rdata", rdata_s, 32'h0);
    do_read(4'h4, rdata_s, resp);
    check("rd1_rresp", resp, 2'b00);
    check("rd1_rdata", rdata_s, 32'h0034_0078);

    // AW, W, AR same cycle on reg2: read sees the old value
    do_write(4'h8, 32'h11, 4'hF, resp, pulses);
    check("r2_init", regs[95:64], 32'h11);
    bus.awaddr = 4'h8; bus.wdata = 32'h22; bus.wstrb = 4'hF; bus.araddr = 4'h8;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    bus.bready = 1'b1; bus.rready = 1'b1;
    bgot = 0; rgot = 0; bresp_s = 2'bxx; rresp_s = 2'bxx; rdata_s = 'x;
    for (int n = 0; n < 12 && !(bgot && rgot); n++) begin
      if (bus.rvalid && !rgot) begin rdata_s = bus.rdata; rresp_s = bus.rresp; rgot = 1; end
      if (bus.bvalid && !bgot) begin bresp_s = bus.bresp; bgot = 1; end
      tick();
    end
    bus.bready = 1'b0; bus.rready = 1'b0;
    check("same_rdata", rdata_s, 32'h11);
    check("same_rresp", rresp_s, 2'b00);
    check("same_bresp", bresp_s, 2'b00);
    check("same_reg2", regs[95:64], 32'h22);

    // Back-pressure: responses held stable, no new address accepted
    bus.awaddr = 4'h0; bus.wdata = 32'hA5A5_A5A5; bus.wstrb = 4'hF; bus.araddr = 4'h4;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
    tick();
    bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    bus.awaddr = 4'h8;
    repeat (3) tick();
    for (int n = 0; n < 10; n++) begin
      check("bp_awready", bus.awready, 0);
      check("bp_wready", bus.wready, 0);
      check("bp_arready", bus.arready, 0);
      check("bp_valids", {bus.bvalid, bus.rvalid}, 2'b11);
      check("bp_rdata", bus.rdata, 32'h0034_0078);
      check("bp_resps", {bus.bresp, bus.rresp}, 4'b0000);
      tick();
    end
    bus.awvalid = 1'b0;
    bus.bready = 1'b1; bus.rready = 1'b1;
    tick();
    bus.bready = 1'b0; bus.rready = 1'b0;
    check("bp_done_valids", {bus.bvalid, bus.rvalid}, 2'b00);
    check("bp_done_ready", {bus.awready, bus.wready, bus.arready}, 3'b111);
    check("bp_reg0", regs[31:0], 32'hA5A5_A5A5);

    // Reset one cycle after the W handshake discards the write
    bus.awaddr = 4'h4; bus.wdata = 32'h55; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    tick();
    areset = 1'b1;
    tick();
    areset = 1'b0;
    check("mid_rst_regs", regs, {RV, RV, RV});
    for (int n = 0; n < 4; n++) begin
      tick();
      check("mid_rst_bvalid", bus.bvalid, 0);
      check("mid_rst_pulse", pulse, 3'b000);
    end
    do_write(4'h4, 32'h55, 4'hF, resp, pulses);
    check("post_rst_resp", resp, 2'b00);
    check("post_rst_pulse", pulses, 3'b010);
    check("post_rst_regs", regs, {RV, 32'h55, RV});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
